// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide controller: datapath width and FSM encoding.
package div_ctrl_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// Execute-stage controller for an external iterative divider: issues operands once,
// waits for the result pulse, and holds HI/LO until the instruction leaves execute.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               div_req,
  input  logic               div_sign,
  input  logic [DIV_W-1:0]   src_a,
  input  logic [DIV_W-1:0]   src_b,
  input  logic               e_advance,
  input  logic               flush,
  output logic               stall_o,
  output logic               opn_valid_o,
  output logic [DIV_W-1:0]   op_a_o,
  output logic [DIV_W-1:0]   op_b_o,
  output logic               op_sign_o,
  output logic               res_ready_o,
  output logic               div_rst_o,
  input  logic               res_valid_i,
  input  logic [2*DIV_W-1:0] result_i,
  output logic [DIV_W-1:0]   hi_o,
  output logic [DIV_W-1:0]   lo_o,
  output logic               hilo_we_o
);

  div_state_t state;

  assign div_rst_o = rst | flush;
  assign stall_o   = div_req & (state != DONE);
  // rst is folded in so an operation abandoned by reset never writes HI/LO.
  assign hilo_we_o = (state == DONE) & e_advance & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a_o      <= '0;
      op_b_o      <= '0;
      op_sign_o   <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      opn_valid_o <= 1'b0;
      res_ready_o <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      opn_valid_o <= 1'b0;
      res_ready_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_req) begin
            state       <= ISSUE;
            op_a_o      <= src_a;
            op_b_o      <= src_b;
            op_sign_o   <= div_sign;
            opn_valid_o <= 1'b1;
          end
        end
        ISSUE: begin
          state       <= BUSY;
          opn_valid_o <= 1'b0;
          res_ready_o <= 1'b1;
        end
        BUSY: begin
          if (res_valid_i) begin
            state       <= DONE;
            hi_o        <= result_i[2*DIV_W-1:DIV_W];
            lo_o        <= result_i[DIV_W-1:0];
            res_ready_o <= 1'b0;
          end
        end
        DONE: begin
          if (e_advance) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl; the bench also plays the external divider.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, div_req, div_sign, e_advance, flush, res_valid_i;
  logic [31:0] src_a, src_b;
  logic [63:0] result_i;
  logic        stall_o, opn_valid_o, op_sign_o, res_ready_o, div_rst_o, hilo_we_o;
  logic [31:0] op_a_o, op_b_o, hi_o, lo_o;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_sign(div_sign),
    .src_a(src_a), .src_b(src_b), .e_advance(e_advance), .flush(flush),
    .stall_o(stall_o), .opn_valid_o(opn_valid_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .op_sign_o(op_sign_o), .res_ready_o(res_ready_o), .div_rst_o(div_rst_o),
    .res_valid_i(res_valid_i), .result_i(result_i), .hi_o(hi_o), .lo_o(lo_o),
    .hilo_we_o(hilo_we_o)
  );

  int unsigned n_vec = 0, n_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  // Divider emulation state
  logic        dv_busy = 1'b0;
  int unsigned dv_cnt = 0, dv_lat = 31;
  logic [63:0] dv_res = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural DIV/DIVU: {remainder, quotient}; divide-by-zero returns {dividend, all-ones}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic tick();
    logic pre_v, pre_r, ps;
    logic [31:0] pa, pb;
    pre_v = opn_valid_o; pre_r = div_rst_o; pa = op_a_o; pb = op_b_o; ps = op_sign_o;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    if (pre_r) dv_busy = 1'b0;
    else if (pre_v) begin
      dv_busy = 1'b1; dv_cnt = dv_lat; dv_res = ref_div(pa, pb, ps);
    end else if (dv_busy) begin
      if (dv_cnt == 0) begin
        res_valid_i = 1'b1; result_i = dv_res; dv_busy = 1'b0;
      end else dv_cnt--;
    end
  endtask

  // Drive a request from IDLE and step through ISSUE into BUSY.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    div_req = 1'b1; src_a = a; src_b = b; div_sign = s;
    tick();
    chk("issue_pulse", opn_valid_o, 1'b1);
    chk("issue_ops", {op_sign_o, op_a_o, op_b_o}, {s, a, b});
    chk("issue_stall", stall_o, 1'b1);
    src_a = $urandom; src_b = $urandom; div_sign = ~s;
    tick();
    chk("busy_ready", {opn_valid_o, res_ready_o}, 2'b01);
  endtask

  // Wait in BUSY until the divider pulses; returns 0 on timeout.
  task automatic wait_result(output bit ok);
    int unsigned n = 0;
    while (!res_valid_i && n < 200) begin
      if (opn_valid_o || !stall_o || !res_ready_o) chk("busy_hold", {opn_valid_o, stall_o, res_ready_o}, 3'b011);
      src_a = $urandom;
      tick();
      n++;
    end
    ok = res_valid_i;
    if (!ok) chk("result_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int unsigned hold, input logic keep_req);
    bit ok;
    logic [63:0] e;
    int unsigned we_cnt = 0;
    e = ref_div(a, b, s);
    issue(a, b, s);
    wait_result(ok);
    if (!ok) return;
    tick();
    exp_hi = e[63:32]; exp_lo = e[31:0];
    chk("done_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
    chk("done_flags", {stall_o, opn_valid_o, res_ready_o, hilo_we_o}, 4'b0000);
    for (int i = 0; i < int'(hold); i++) begin
      if (i == 1) begin res_valid_i = 1'b1; result_i = {$urandom, $urandom}; end
      tick();
      chk("done_hold", {hi_o, lo_o, stall_o, opn_valid_o, hilo_we_o}, {exp_hi, exp_lo, 3'b000});
    end
    e_advance = 1'b1; div_req = keep_req;
    #1;
    if (hilo_we_o) we_cnt++;
    tick();
    e_advance = 1'b0;
    #1;
    if (hilo_we_o) we_cnt++;
    chk("we_pulses", we_cnt, 1);
    chk("idle_after_adv", {res_ready_o, stall_o}, {1'b0, keep_req});
  endtask

  initial begin
    bit ok;
    rst = 1'b1; div_req = 1'b0; div_sign = 1'b0; src_a = '0; src_b = '0;
    e_advance = 1'b0; flush = 1'b0; res_valid_i = 1'b0; result_i = '0;
    #1;
    chk("rst_divrst", div_rst_o, 1'b1);
    tick(); tick();
    chk("rst_outs", {op_a_o, op_b_o, op_sign_o, hi_o, lo_o, opn_valid_o, res_ready_o, hilo_we_o}, '0);
    rst = 1'b0;
    #1;
    chk("rst_release", {div_rst_o, stall_o}, 2'b00);

    dv_lat = 31;
    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    chk("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    chk("div_m7_2", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Flush ten cycles after ISSUE.
    issue(32'd50, 32'd5, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1; div_req = 1'b0;
    #1;
    chk("flush_rst_we", {div_rst_o, hilo_we_o}, 2'b10);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_after", {div_rst_o, res_ready_o, opn_valid_o, stall_o}, 4'b0000);
    chk("flush_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
    run_div(32'd9, 32'd3, 1'b0, 0, 1'b0);
    chk("divu_9_3", {hi_o, lo_o}, {32'd0, 32'd3});

    // Long downstream stall, then back-to-back pair.
    run_div(32'd1000, 32'd33, 1'b0, 5, 1'b1);
    dv_lat = 5;
    run_div(32'd77, 32'd10, 1'b1, 0, 1'b0);
    chk("b2b_second", {hi_o, lo_o}, {32'd7, 32'd7});

    // Divide by zero completes normally.
    run_div(32'd1234, 32'd0, 1'b1, 1, 1'b0);

    // Stray result pulse in IDLE is ignored.
    res_valid_i = 1'b1; result_i = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    chk("stray_result", {hi_o, lo_o, res_ready_o}, {exp_hi, exp_lo, 1'b0});

    // Flush coinciding with the result pulse wins.
    dv_lat = 3;
    issue(32'd88, 32'd8, 1'b0);
    wait_result(ok);
    if (ok) begin
      flush = 1'b1; div_req = 1'b0;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_vs_result", {hi_o, lo_o, res_ready_o, stall_o}, {exp_hi, exp_lo, 2'b00});
      tick();
      chk("flush_vs_result_we", hilo_we_o, 1'b0);
    end

    // Reset during an operation.
    issue(32'd99, 32'd4, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midop_rst", {div_rst_o, hilo_we_o}, 2'b10);
    tick();
    rst = 1'b0; div_req = 1'b0;
    #1;
    chk("midop_rst_outs", {hi_o, lo_o, op_a_o, opn_valid_o, res_ready_o}, '0);
    exp_hi = '0; exp_lo = '0;

    // Randomized divides.
    for (int k = 0; k < 10; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      dv_lat = $urandom_range(0, 40);
      run_div(a, b, 1'($urandom), $urandom_range(0, 4), 1'($urandom));
    end
    div_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 div_req  in  1  execute stage holds a valid DIV/DIVU instruction.
REQ-004 div_sign  in  1  1 = DIV (signed), 0 = DIVU.
REQ-005 src_a / src_b  in  32 each  dividend / divisor from execute stage; may change every cycle through forwarding.
REQ-006 e_advance  in  1  execute stage hands its instruction to memory stage this cycle.
REQ-007 flush  in  1  exception/flush kills the execute-stage instruction.
REQ-008 stall_o  out  1  hold execute stage; divide not finished.
REQ-009 opn_valid_o  out  1  operands valid toward the divider.
REQ-010 op_a_o / op_b_o / op_sign_o  out  32/32/1  registered operands toward the divider.
REQ-011 res_ready_o  out  1  controller can accept a result toward the divider.
REQ-012 div_rst_o  out  1  divider reset = rst OR flush, combinational.
REQ-013 res_valid_i  in  1  divider result valid; single-cycle pulse.
REQ-014 result_i  in  64  {remainder, quotient} from the divider.
REQ-015 hi_o / lo_o  out  32 each  captured remainder / quotient.
REQ-016 hilo_we_o  out  1  single-cycle write enable for HI/LO.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, BUSY, DONE.
REQ-018 IDLE SHALL go to ISSUE when div_req=1 and flush=0, capturing src_a, src_b and div_sign into op_*_o on the same edge.
REQ-019 opn_valid_o SHALL be 1 only in ISSUE, for exactly one cycle; ISSUE SHALL go to BUSY unconditionally.
REQ-020 The divider SHALL NOT be re-triggered: opn_valid_o SHALL be 0 in BUSY and DONE even when div_req stays 1.
REQ-021 res_ready_o SHALL be 1 in BUSY and 0 otherwise.
REQ-022 In BUSY, res_valid_i=1 SHALL capture result_i[63:32] into hi_o and result_i[31:0] into lo_o, and the FSM SHALL go to DONE.
REQ-023 Completion SHALL be tracked by res_valid_i only, with no fixed-latency counter; the nominal divider latency is 33 cycles from the ISSUE edge.
REQ-024 res_valid_i outside BUSY SHALL be ignored.
REQ-025 stall_o SHALL equal div_req AND (state != DONE), combinational.
REQ-026 In DONE, hilo_we_o SHALL equal e_advance AND NOT flush.
REQ-027 DONE SHALL go to IDLE on e_advance; otherwise it SHALL hold hi_o/lo_o and stay in DONE, which covers a downstream stall.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge, set hilo_we_o=0 that cycle, drive div_rst_o=1 that cycle, and leave hi_o/lo_o unchanged.
REQ-029 When flush and res_valid_i arrive in the same cycle, flush SHALL win: no capture and no DONE.
REQ-030 Back-to-back divides: the DONE→IDLE edge SHALL be followed by a new ISSUE on the next edge when div_req=1.
REQ-031 Divide by zero SHALL complete normally; the values captured are whatever the divider returns.

Reset
REQ-032 rst SHALL set state=IDLE, op_a_o=op_b_o=0, op_sign_o=0, hi_o=lo_o=0, opn_valid_o=0, res_ready_o=0 and hilo_we_o=0.
REQ-033 div_rst_o SHALL be 1 during rst.
REQ-034 A reset during an operation SHALL abandon it with no hilo_we_o pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (2 bits) and DIV_W=32.
REQ-036 No sub-module is needed; the divider SHALL be instantiated beside div_ctrl by the execute stage, not inside it.

Verification
REQ-037 DIVU with 100 and 7 -> one opn_valid pulse, stall until res_valid, then lo_o=14, hi_o=2, and hilo_we_o=1 on e_advance.
REQ-038 DIV with 0xFFFFFFF9 (-7) and 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-039 Flush 10 cycles after ISSUE -> div_rst_o=1 for 1 cycle, state IDLE, no hilo_we_o, hi/lo unchanged; a following DIVU with 9 and 3 gives lo_o=3, hi_o=0.
REQ-040 DONE with e_advance=0 for 5 cycles -> stall_o=0, opn_valid_o stays 0, hi/lo stable, exactly one hilo_we_o when e_advance=1.
REQ-041 src_a changes while BUSY -> result still reflects the operands captured at ISSUE.
REQ-042 Two divides back to back -> two ISSUE pulses, two hilo_we_o pulses and correct results for both.
